// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C bus monitor: FSM states and the record
// format pushed into the record FIFO.
package i2c_mon_pkg;

  localparam int REC_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    BITS,
    ACK
  } mon_state_e;

  typedef struct packed {
    logic       first;
    logic       nack;
    logic [7:0] data;
  } mon_rec_t;

endpackage

// File: rtl/i2c_mon_fifo.sv
// Generic synchronous first-word-fall-through FIFO with exact occupancy.
// A push while full only lands when a pop frees the head in the same cycle.
module i2c_mon_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr;
  logic             rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C monitor: synchronises and glitch-filters SCL/SDA, decodes
// START/rSTART/STOP, bytes and ACK/NACK, and queues byte records.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int FIFO_DEPTH  = 8,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             pclk_i,
  input  logic             preset_i,
  input  logic             enable_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic [REC_W-1:0] rec_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LW-1:0]    level_o,
  output logic             start_o,
  output logic             rstart_o,
  output logic             stop_o,
  output logic             abort_o,
  output logic             busy_o,
  output logic             overflow_o,
  input  logic             overflow_clr_i
);

  localparam int CW = $clog2(FILT_LEN + 1);

  // Index 0 carries SCL, index 1 carries SDA throughout.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [1:0]             raw_s, filt, prev;
  logic [CW-1:0]          fcnt [2];

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign raw_s = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      filt <= '1;
      prev <= '1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      prev <= filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (raw_s[i] != filt[i]) begin
          if (fcnt[i] == CW'(FILT_LEN - 1)) begin
            filt[i] <= raw_s[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_q, sda_q;
  logic start_det, stop_det, scl_rise;

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_q     = prev[0];
  assign sda_q     = prev[1];
  assign start_det = scl_q && scl_f && sda_q && !sda_f;
  assign stop_det  = scl_q && scl_f && !sda_q && sda_f;
  assign scl_rise  = !scl_q && scl_f;

  mon_state_e state;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       first;
  logic       mid_byte;
  logic       push, pop, full, empty;
  mon_rec_t   push_rec;

  // The SCL rise that opens a START/STOP was already counted as a bit, so a
  // single counted edge means no real data bit has been transferred yet.
  assign mid_byte = (state == ACK) || (bcnt > 3'd1);
  assign push     = enable_i && (state == ACK) && scl_rise;
  assign push_rec = '{first: first, nack: sda_f, data: shreg};

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state    <= IDLE;
      bcnt     <= '0;
      shreg    <= '0;
      first    <= 1'b0;
      start_o  <= 1'b0;
      rstart_o <= 1'b0;
      stop_o   <= 1'b0;
      abort_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      start_o  <= 1'b0;
      rstart_o <= 1'b0;
      stop_o   <= 1'b0;
      abort_o  <= 1'b0;
      if (!enable_i) begin
        state  <= IDLE;
        bcnt   <= '0;
        busy_o <= 1'b0;
      end else if (state != IDLE && stop_det) begin
        stop_o  <= 1'b1;
        abort_o <= mid_byte;
        busy_o  <= 1'b0;
        state   <= IDLE;
        bcnt    <= '0;
      end else if (start_det) begin
        bcnt   <= '0;
        first  <= 1'b1;
        state  <= BITS;
        busy_o <= 1'b1;
        if (state == IDLE) begin
          start_o <= 1'b1;
        end else begin
          rstart_o <= 1'b1;
          abort_o  <= mid_byte;
        end
      end else if (scl_rise) begin
        case (state)
          BITS: begin
            shreg <= {shreg[6:0], sda_f};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= ACK;
          end
          ACK: begin
            state <= BITS;
            bcnt  <= '0;
            first <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pop     = valid_o && ready_i;
  assign valid_o = !empty;

  i2c_mon_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (pclk_i),
    .rst  (preset_i),
    .push (push),
    .pop  (pop),
    .din  (push_rec),
    .dout (rec_o),
    .level(level_o),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge pclk_i) begin
    if (preset_i)                   overflow_o <= 1'b0;
    else if (push && full && !pop)  overflow_o <= 1'b1;
    else if (overflow_clr_i)        overflow_o <= 1'b0;
  end

endmodule
